// File: rtl/spi_flash_rom_responder_pkg.sv
// Shared constants and types for the SPI flash ROM responder:
// opcodes, frame field lengths and the FSM state encoding.
package spi_flash_rom_responder_pkg;

    localparam logic [7:0] OPC_READ      = 8'h03;
    localparam logic [7:0] OPC_FAST_READ = 8'h0B;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DUMMY_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    function automatic logic opcode_supported(input logic [7:0] opc);
        return (opc == OPC_READ) || (opc == OPC_FAST_READ);
    endfunction

endpackage

// File: rtl/spi_flash_rom_responder_if.sv
// SPI pins, memory read port and status flags of the flash ROM responder.
// The slave modport is the responder; the master modport is the initiator/memory side.
interface spi_flash_rom_responder_if #(
    parameter int MEM_ADDR_W = 16
);
    logic                  spi_cs_n;
    logic                  spi_sclk;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic                  mem_rd;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [7:0]            mem_data;
    logic                  busy;
    logic                  cmd_err;

    modport slave (
        input  spi_cs_n, spi_sclk, spi_mosi, mem_data,
        output spi_miso, spi_miso_oe, mem_rd, mem_addr, busy, cmd_err
    );

    modport master (
        output spi_cs_n, spi_sclk, spi_mosi, mem_data,
        input  spi_miso, spi_miso_oe, mem_rd, mem_addr, busy, cmd_err
    );
endinterface

// File: rtl/spi_flash_rom_responder_pin_sync.sv
// N-stage synchroniser for one asynchronous pin, with rise/fall flags
// derived from the synchronised value against its previous sample.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Chain resets low so a pin that is really high shows up as a rise after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_flash_rom_responder.sv
// SPI mode-0 responder emulating a serial flash ROM: decodes READ / FAST READ,
// fetches bytes from a synchronous memory port and shifts them out MSB first.
module spi_flash_rom_responder
    import spi_flash_rom_responder_pkg::*;
#(
    parameter int MEM_ADDR_W  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    spi_flash_rom_responder_if.slave bus
);

    logic cs_sync, cs_rise, cs_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise, mosi_fall;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.spi_cs_n),
        .sync (cs_sync),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.spi_sclk),
        .sync (sclk_sync),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.spi_mosi),
        .sync (mosi_sync),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    state_t                 state_q, state_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             cmd_sr_q, cmd_sr_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   dummy_q, dummy_d;
    logic [7:0]             tx_buf_q, tx_buf_d;
    logic                   rd_pend_q, rd_pend_d;
    logic                   armed_q, armed_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   cmd_err_q, cmd_err_d;
    logic [MEM_ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [2:0]             bit_idx;
    logic                   unused_ok;

    assign bit_idx = bit_cnt_q[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            cmd_sr_q   <= '0;
            addr_q     <= '0;
            dummy_q    <= 1'b0;
            tx_buf_q   <= '0;
            rd_pend_q  <= 1'b0;
            armed_q    <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            mem_rd_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_sr_q   <= cmd_sr_d;
            addr_q     <= addr_d;
            dummy_q    <= dummy_d;
            tx_buf_q   <= tx_buf_d;
            rd_pend_q  <= rd_pend_d;
            armed_q    <= armed_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            mem_rd_q   <= mem_rd_d;
            cmd_err_q  <= cmd_err_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Decoding only starts once cs_n has been seen high since reset, so a frame
    // interrupted by rst is never decoded from its middle.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_sr_d   = cmd_sr_q;
        addr_d     = addr_q;
        dummy_d    = dummy_q;
        tx_buf_d   = rd_pend_q ? bus.mem_data : tx_buf_q;
        rd_pend_d  = mem_rd_q;
        armed_d    = armed_q | cs_rise;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        mem_rd_d   = 1'b0;
        cmd_err_d  = 1'b0;
        mem_addr_d = mem_addr_q;

        if (cs_sync) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            tx_buf_d  = tx_buf_q;
            rd_pend_d = 1'b0;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                    end
                end

                ST_CMD: begin
                    if (sclk_rise) begin
                        cmd_sr_d = {cmd_sr_q[6:0], mosi_sync};
                        if (bit_cnt_q == 6'(CMD_BITS - 1)) begin
                            bit_cnt_d = '0;
                            dummy_d   = (cmd_sr_d == OPC_FAST_READ);
                            if (opcode_supported(cmd_sr_d)) begin
                                state_d = ST_ADDR;
                            end else begin
                                state_d   = ST_IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end

                ST_ADDR: begin
                    if (sclk_rise) begin
                        addr_d = {addr_q[ADDR_BITS-2:0], mosi_sync};
                        if (bit_cnt_q == 6'(ADDR_BITS - 1)) begin
                            bit_cnt_d  = '0;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr_d[MEM_ADDR_W-1:0];
                            state_d    = dummy_q ? ST_DUMMY : ST_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end

                ST_DUMMY: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q == 6'(DUMMY_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = ST_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end

                // Presenting bit0 prefetches the next byte, which lands in tx_buf
                // long before the next SCLK fall given the 8x clock ratio.
                ST_DATA: begin
                    if (sclk_fall) begin
                        miso_d    = tx_buf_d[3'd7 - bit_idx];
                        miso_oe_d = 1'b1;
                        bit_cnt_d = {3'b000, bit_idx + 3'd1};
                        if (bit_idx == 3'd7) begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = mem_addr_q + MEM_ADDR_W'(1);
                        end
                    end
                end

                ST_IGNORE: begin
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = miso_oe_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.cmd_err     = cmd_err_q;
    assign bus.busy        = (state_q != ST_IDLE);

    assign unused_ok = &{1'b0, cs_fall, mosi_rise, mosi_fall, sclk_sync,
                         cmd_sr_q[7], addr_q[ADDR_BITS-1]};

endmodule

// File: tb/tb_spi_flash_rom_responder.sv
// Self-checking bench for spi_flash_rom_responder: an SPI initiator model
// plus a memory model, with expected bytes and read addresses queued per frame.
module tb_spi_flash_rom_responder;
    import spi_flash_rom_responder_pkg::*;

    localparam int W      = 16;
    localparam int STAGES = 2;
    localparam int HALF   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_flash_rom_responder_if #(.MEM_ADDR_W(W)) bus ();

    spi_flash_rom_responder #(
        .MEM_ADDR_W  (W),
        .SYNC_STAGES (STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]   mem [0:65535];
    logic [7:0]   exp_data_q[$];
    logic [W-1:0] exp_addr_q[$];
    logic [W-1:0] rd_q[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int rd_cnt  = 0;
    int err_cnt = 0;
    int oe_cnt  = 0;

    // Memory returns data exactly one clk after the strobe; junk otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
        else            bus.mem_data <= 8'h3C;
    end

    always @(negedge clk) begin
        if (bus.mem_rd) begin
            rd_cnt++;
            rd_q.push_back(bus.mem_addr);
        end
        if (bus.cmd_err)     err_cnt++;
        if (bus.spi_miso_oe) oe_cnt++;
    end

    initial begin
        #20000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] model_byte(input logic [W-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        bus.spi_mosi = b;
        wait_clk(HALF);
        bus.spi_sclk = 1'b1;
        r = bus.spi_miso;
        wait_clk(HALF);
        bus.spi_sclk = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] t, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) xfer_bit(t[i], r[i]);
    endtask

    task automatic xfer_bits(input logic [31:0] v, input int n);
        logic r;
        for (int i = n - 1; i >= 0; i--) xfer_bit(v[i], r);
    endtask

    task automatic cs_low();
        bus.spi_cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_high();
        wait_clk(2);
        bus.spi_cs_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic send_hdr(input logic [7:0] opc, input logic [23:0] a);
        logic [7:0] junk;
        xfer_byte(opc, junk);
        xfer_byte(a[23:16], junk);
        xfer_byte(a[15:8], junk);
        xfer_byte(a[7:0], junk);
    endtask

    // n bytes clocked out imply n+1 reads: the byte after the last one is prefetched.
    task automatic push_expect(input logic [W-1:0] start, input int n);
        for (int i = 0; i < n; i++) exp_data_q.push_back(model_byte(start + W'(i)));
        for (int i = 0; i <= n; i++) exp_addr_q.push_back(start + W'(i));
    endtask

    task automatic read_bytes(input int n, input string name);
        logic [7:0] rx, e;
        for (int i = 0; i < n; i++) begin
            xfer_byte(8'h00, rx);
            tests_run++;
            if (exp_data_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL %s byte %0d: got %h, expected nothing queued", name, i, rx);
            end else begin
                e = exp_data_q.pop_front();
                if (rx !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL %s byte %0d: got %h, expected %h", name, i, rx, e);
                end
            end
        end
    endtask

    task automatic check_addrs(input string name);
        int n;
        tests_run++;
        if (rd_q.size() != exp_addr_q.size()) begin
            tests_failed++;
            $display("[TB] FAIL %s read count: got %0d, expected %0d", name, rd_q.size(), exp_addr_q.size());
        end
        n = (rd_q.size() < exp_addr_q.size()) ? rd_q.size() : exp_addr_q.size();
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (rd_q[i] !== exp_addr_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL %s mem_addr %0d: got %h, expected %h", name, i, rd_q[i], exp_addr_q[i]);
            end
        end
        rd_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        logic [W+4:0] got;
        got = {bus.spi_miso, bus.spi_miso_oe, bus.mem_rd, bus.busy, bus.cmd_err, bus.mem_addr};
        tests_run++;
        if (got !== '0) begin
            tests_failed++;
            $display("[TB] FAIL %s outputs {miso,oe,rd,busy,err,addr}: got %h, expected 0", name, got);
        end
    endtask

    task automatic test_reset();
        wait_clk(3);
        check_idle_outputs("reset_held");
        rst = 1'b0;
        wait_clk(4);
        check_idle_outputs("reset_released");
        rd_q.delete();
    endtask

    task automatic test_read();
        push_expect(16'h0010, 2);
        cs_low();
        send_hdr(OPC_READ, 24'h000010);
        read_bytes(2, "read");
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL read busy: got %b, expected 1", bus.busy);
        end
        cs_high();
        check_addrs("read");
    endtask

    task automatic test_fast_read();
        logic [7:0] junk;
        int o;
        push_expect(16'h0100, 1);
        cs_low();
        send_hdr(OPC_FAST_READ, 24'h000100);
        o = oe_cnt;
        xfer_byte(8'hFF, junk);
        tests_run++;
        if (oe_cnt != o) begin
            tests_failed++;
            $display("[TB] FAIL fast_read dummy oe cycles: got %0d, expected 0", oe_cnt - o);
        end
        read_bytes(1, "fast_read");
        tests_run++;
        if (bus.spi_miso_oe !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL fast_read data oe: got %b, expected 1", bus.spi_miso_oe);
        end
        cs_high();
        tests_run++;
        if (bus.spi_miso_oe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fast_read oe after cs: got %b, expected 0", bus.spi_miso_oe);
        end
        check_addrs("fast_read");
    endtask

    task automatic test_bad_opcode();
        int e, o, r;
        e = err_cnt; o = oe_cnt; r = rd_cnt;
        cs_low();
        xfer_bits(32'h9F, 8);
        xfer_bits(32'h12345678, 32);
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bad_opcode busy: got %b, expected 1", bus.busy);
        end
        cs_high();
        tests_run++;
        if (err_cnt - e != 1) begin
            tests_failed++;
            $display("[TB] FAIL bad_opcode cmd_err pulses: got %0d, expected 1", err_cnt - e);
        end
        tests_run++;
        if (oe_cnt != o || rd_cnt != r) begin
            tests_failed++;
            $display("[TB] FAIL bad_opcode oe/rd: got %0d/%0d, expected 0/0", oe_cnt - o, rd_cnt - r);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bad_opcode busy after cs: got %b, expected 0", bus.busy);
        end
        rd_q.delete();
    endtask

    task automatic test_addr_wrap();
        push_expect(16'hFFFF, 2);
        cs_low();
        send_hdr(OPC_READ, 24'h12FFFF);
        read_bytes(2, "addr_wrap");
        cs_high();
        check_addrs("addr_wrap");
    endtask

    task automatic test_abort();
        logic [7:0] junk;
        int r;
        r = rd_cnt;
        cs_low();
        xfer_byte(OPC_READ, junk);
        xfer_bits(32'h0, 12);
        cs_high();
        tests_run++;
        if (rd_cnt != r || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort rd/busy: got %0d/%b, expected 0/0", rd_cnt - r, bus.busy);
        end
        rd_q.delete();
        push_expect(16'h0020, 1);
        cs_low();
        send_hdr(OPC_READ, 24'h000020);
        read_bytes(1, "abort_retry");
        cs_high();
        check_addrs("abort_retry");
    endtask

    task automatic test_rst_mid_frame();
        int r, e;
        cs_low();
        send_hdr(OPC_READ, 24'h000040);
        xfer_bits(32'h0, 4);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check_idle_outputs("rst_mid_frame");
        r = rd_cnt; e = err_cnt;
        send_hdr(OPC_READ, 24'h000040);
        xfer_bits(32'h0, 8);
        tests_run++;
        if (rd_cnt != r || err_cnt != e || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_no_decode rd/err/busy: got %0d/%0d/%b, expected 0/0/0",
                     rd_cnt - r, err_cnt - e, bus.busy);
        end
        cs_high();
        rd_q.delete();
        push_expect(16'h0041, 1);
        cs_low();
        send_hdr(OPC_READ, 24'h000041);
        read_bytes(1, "rst_recover");
        cs_high();
        check_addrs("rst_recover");
    endtask

    initial begin
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'hA5;
        test_reset();
        test_read();
        test_fast_read();
        test_bad_opcode();
        test_addr_wrap();
        test_abort();
        test_rst_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
